// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the expr_check streaming expression validator.
// Bracket support is controlled by the EXPR_CHECK_PAREN_EN macro in the consuming files.
package expr_pkg;

   typedef enum logic [2:0] {
      S_EMPTY,
      S_EXPECT,
      S_NUM,
      S_CLOSE,
      S_ERR
   } expr_state_t;

   typedef enum logic [2:0] {
      C_DIGIT,
      C_OP,
      C_LPAR,
      C_RPAR,
      C_NUL,
      C_OTHER
   } expr_class_t;

   localparam logic [7:0] CH_NUL   = 8'h00;
   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_STAR  = 8'h2A;
   localparam logic [7:0] CH_LPAR  = 8'h28;
   localparam logic [7:0] CH_RPAR  = 8'h29;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_0) && (c <= CH_9);
   endfunction

endpackage

// File: rtl/expr_classify.sv
// Combinational byte classifier for expr_check.
// With EXPR_CHECK_PAREN_EN undefined, '(' and ')' fall into the OTHER class.
module expr_classify
   import expr_pkg::*;
#(
   parameter int unsigned ALLOW_SUB = 0
) (
   input  logic [7:0]  i_char,
   output expr_class_t o_class
);

   always_comb begin
      o_class = C_OTHER;
      if (i_char == CH_NUL) begin
         o_class = C_NUL;
      end else if (is_digit(i_char)) begin
         o_class = C_DIGIT;
      end else if ((i_char == CH_PLUS) || (i_char == CH_STAR)) begin
         o_class = C_OP;
      end else if ((i_char == CH_MINUS) && (ALLOW_SUB != 0)) begin
         o_class = C_OP;
`ifdef EXPR_CHECK_PAREN_EN
      end else if (i_char == CH_LPAR) begin
         o_class = C_LPAR;
      end else if (i_char == CH_RPAR) begin
         o_class = C_RPAR;
`endif
      end
   end

endmodule

// File: rtl/expr_check.sv
// Streaming ASCII arithmetic-expression validator: one byte per accepted cycle, Moore outputs.
// Bracket nesting is compiled in only when EXPR_CHECK_PAREN_EN is defined.
module expr_check
   import expr_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = 4,
   parameter int unsigned MAX_DEPTH  = 7,
   parameter int unsigned ALLOW_SUB  = 0,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                             clk,
   input  logic                             clr,
   input  logic                             in_valid,
   input  logic [7:0]                       in,
   output logic                             out,
   output logic                             err,
   output logic [$clog2(MAX_DEPTH+1)-1:0]   depth,
   output logic [CNT_W-1:0]                 num_cnt
);

   localparam int unsigned DW  = $clog2(MAX_DEPTH + 1);
   localparam int unsigned DCW = $clog2(MAX_DIGITS + 1);

   expr_class_t      w_class;
   expr_state_t      r_state;
   expr_state_t      w_nxt_state;
   logic [DCW-1:0]   r_dcnt;
   logic [DCW-1:0]   w_nxt_dcnt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_inc;
   logic             w_nxt_top;
   logic             r_out;
   logic             r_err;
`ifdef EXPR_CHECK_PAREN_EN
   logic [DW-1:0]    r_depth;
   logic [DW-1:0]    w_nxt_depth;
`endif

   expr_classify #(
      .ALLOW_SUB(ALLOW_SUB)
   ) u_classify (
      .i_char (in),
      .o_class(w_class)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_dcnt  = r_dcnt;
      w_cnt_inc   = 1'b0;
`ifdef EXPR_CHECK_PAREN_EN
      w_nxt_depth = r_depth;
`endif
      if (in_valid && (w_class != C_NUL)) begin
         case (r_state)
            S_EMPTY, S_EXPECT: begin
               case (w_class)
                  C_DIGIT: begin
                     w_nxt_state = S_NUM;
                     w_nxt_dcnt  = DCW'(1);
                     w_cnt_inc   = 1'b1;
                  end
`ifdef EXPR_CHECK_PAREN_EN
                  C_LPAR: begin
                     if (r_depth == DW'(MAX_DEPTH)) begin
                        w_nxt_state = S_ERR;
                     end else begin
                        w_nxt_state = S_EXPECT;
                        w_nxt_depth = r_depth + DW'(1);
                     end
                  end
`endif
                  default: w_nxt_state = S_ERR;
               endcase
            end
            S_NUM: begin
               case (w_class)
                  C_DIGIT: begin
                     if (r_dcnt == DCW'(MAX_DIGITS)) begin
                        w_nxt_state = S_ERR;
                     end else begin
                        w_nxt_dcnt = r_dcnt + DCW'(1);
                     end
                  end
                  C_OP: w_nxt_state = S_EXPECT;
`ifdef EXPR_CHECK_PAREN_EN
                  C_RPAR: begin
                     if (r_depth != '0) begin
                        w_nxt_state = S_CLOSE;
                        w_nxt_depth = r_depth - DW'(1);
                     end else begin
                        w_nxt_state = S_ERR;
                     end
                  end
`endif
                  default: w_nxt_state = S_ERR;
               endcase
            end
            S_CLOSE: begin
               // A digit or '(' right after ')' would be implicit multiplication.
               case (w_class)
                  C_OP: w_nxt_state = S_EXPECT;
`ifdef EXPR_CHECK_PAREN_EN
                  C_RPAR: begin
                     if (r_depth != '0) begin
                        w_nxt_depth = r_depth - DW'(1);
                     end else begin
                        w_nxt_state = S_ERR;
                     end
                  end
`endif
                  default: w_nxt_state = S_ERR;
               endcase
            end
            default: w_nxt_state = S_ERR;
         endcase
      end
`ifdef EXPR_CHECK_PAREN_EN
      w_nxt_top = (w_nxt_depth == '0);
`else
      w_nxt_top = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= S_EMPTY;
         r_dcnt  <= '0;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_err   <= 1'b0;
`ifdef EXPR_CHECK_PAREN_EN
         r_depth <= '0;
`endif
      end else begin
         r_state <= w_nxt_state;
         r_dcnt  <= w_nxt_dcnt;
         if (w_cnt_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         // Outputs are registered from next state so they depend on state only, never on in.
         r_out <= ((w_nxt_state == S_NUM) || (w_nxt_state == S_CLOSE)) && w_nxt_top;
         r_err <= (w_nxt_state == S_ERR);
`ifdef EXPR_CHECK_PAREN_EN
         r_depth <= w_nxt_depth;
`endif
      end
   end

   assign out     = r_out;
   assign err     = r_err;
   assign num_cnt = r_cnt;
`ifdef EXPR_CHECK_PAREN_EN
   assign depth   = r_depth;
`else
   assign depth   = '0;
`endif

endmodule

// File: tb/tb_expr_check.sv
// Scoreboard bench for expr_check: two configurations share one byte stream and are checked
// against a grammar-level model tracking the previous significant character.
module tb_expr_check;

`ifdef EXPR_CHECK_PAREN_EN
   localparam bit PAREN = 1'b1;
`else
   localparam bit PAREN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic       in_valid;
   logic [7:0] in_b;

   logic       a_out, a_err;
   logic [2:0] a_depth;
   logic [7:0] a_cnt;
   logic       b_out, b_err;
   logic [1:0] b_depth;
   logic [2:0] b_cnt;

   expr_check #(.MAX_DIGITS(4), .MAX_DEPTH(7), .ALLOW_SUB(0), .CNT_W(8)) u_a (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_b),
      .out(a_out), .err(a_err), .depth(a_depth), .num_cnt(a_cnt)
   );

   expr_check #(.MAX_DIGITS(2), .MAX_DEPTH(2), .ALLOW_SUB(1), .CNT_W(3)) u_b (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_b),
      .out(b_out), .err(b_err), .depth(b_depth), .num_cnt(b_cnt)
   );

   always #5 clk = ~clk;

   // prev: 0 nothing yet, 1 digit, 2 operator, 3 '(', 4 ')'
   typedef struct {
      int prev;
      int run;
      int dep;
      int cnt;
      bit err;
   } mdl_t;

   typedef struct {
      int o_out;
      int o_err;
      int o_dep;
      int o_cnt;
   } exp_t;

   typedef struct {
      exp_t a;
      exp_t b;
   } pair_t;

   mdl_t  ma, mb;
   pair_t q[$];
   int    total = 0;
   int    bad   = 0;

   function automatic mdl_t m_init();
      mdl_t m;
      m.prev = 0; m.run = 0; m.dep = 0; m.cnt = 0; m.err = 1'b0;
      return m;
   endfunction

   function automatic mdl_t m_step(input mdl_t m, input logic [7:0] c, input int maxd,
                                   input int maxdep, input bit sub, input int cntmax);
      mdl_t n;
      bit   dig, op, lp, rp, want_operand, have_operand;
      n = m;
      if (m.err || c == 8'h00) return n;
      dig = (c >= 8'h30) && (c <= 8'h39);
      op  = (c == 8'h2B) || (c == 8'h2A) || (sub && c == 8'h2D);
      lp  = PAREN && (c == 8'h28);
      rp  = PAREN && (c == 8'h29);
      want_operand = (m.prev == 0) || (m.prev == 2) || (m.prev == 3);
      have_operand = (m.prev == 1) || (m.prev == 4);
      if (dig && want_operand) begin
         n.prev = 1; n.run = 1;
         n.cnt  = (m.cnt < cntmax) ? m.cnt + 1 : cntmax;
      end else if (dig && m.prev == 1 && m.run < maxd) begin
         n.run = m.run + 1;
      end else if (op && have_operand) begin
         n.prev = 2;
      end else if (lp && want_operand && m.dep < maxdep) begin
         n.prev = 3; n.dep = m.dep + 1;
      end else if (rp && have_operand && m.dep > 0) begin
         n.prev = 4; n.dep = m.dep - 1;
      end else begin
         n.err = 1'b1;
      end
      return n;
   endfunction

   function automatic exp_t m_exp(input mdl_t m);
      exp_t e;
      e.o_out = (!m.err && (m.prev == 1 || m.prev == 4) && m.dep == 0) ? 1 : 0;
      e.o_err = m.err ? 1 : 0;
      e.o_dep = m.dep;
      e.o_cnt = m.cnt;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic send(input bit v, input logic [7:0] c);
      pair_t p;
      @(negedge clk);
      in_valid = v;
      in_b     = c;
      if (v) begin
         ma = m_step(ma, c, 4, 7, 1'b0, 255);
         mb = m_step(mb, c, 2, 2, 1'b1, 7);
      end
      p.a = m_exp(ma);
      p.b = m_exp(mb);
      q.push_back(p);
   endtask

   task automatic run_str(input string s);
      for (int i = 0; i < s.len(); i++) send(1'b1, s[i]);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a_out"}, a_out, 0);
      chk({tag, "_a_err"}, a_err, 0);
      chk({tag, "_a_depth"}, a_depth, 0);
      chk({tag, "_a_cnt"}, a_cnt, 0);
      chk({tag, "_b_out"}, b_out, 0);
      chk({tag, "_b_err"}, b_err, 0);
      chk({tag, "_b_depth"}, b_depth, 0);
      chk({tag, "_b_cnt"}, b_cnt, 0);
   endtask

   // Asynchronous clear strictly between edges; outputs must drop without a clock.
   task automatic clr_pulse();
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      clr = 1'b1;
      #1;
      chk_all_zero("clr_async");
      ma = m_init();
      mb = m_init();
      clr = 1'b0;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      pair_t p;
      #1;
      if (q.size() != 0) begin
         p = q.pop_front();
         chk("a_out", a_out, p.a.o_out);
         chk("a_err", a_err, p.a.o_err);
         chk("a_depth", a_depth, p.a.o_dep);
         chk("a_cnt", a_cnt, p.a.o_cnt);
         chk("b_out", b_out, p.b.o_out);
         chk("b_err", b_err, p.b.o_err);
         chk("b_depth", b_depth, p.b.o_dep);
         chk("b_cnt", b_cnt, p.b.o_cnt);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string alpha;
      int    len, r;
      alpha    = "0123456789+*-()+*(1)";
      ma       = m_init();
      mb       = m_init();
      clr      = 1'b1;
      in_valid = 1'b0;
      in_b     = 8'h00;
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      clr = 1'b0;

      run_str("1+2");
      settle();
      chk("plan_1p2_out", a_out, 1);
      chk("plan_1p2_cnt", a_cnt, 2);

      clr_pulse(); run_str("12*34");
      settle();
      chk("plan_md2_out", b_out, 1);
      chk("plan_md2_cnt", b_cnt, 2);

      clr_pulse(); run_str("123");
      settle();
      chk("plan_md2_err", b_err, 1);
      chk("plan_md2_errout", b_out, 0);

      clr_pulse(); run_str("5-3");
      settle();
      chk("plan_nosub_err", a_err, 1);
      chk("plan_sub_out", b_out, 1);

      clr_pulse(); run_str("(1+2)*3");
      settle();
      chk("plan_paren_out", a_out, PAREN ? 1 : 0);
      chk("plan_paren_err", a_err, PAREN ? 0 : 1);

      clr_pulse(); run_str(")");
      clr_pulse(); run_str("(((");
      settle();
      chk("plan_depth_b_err", b_err, 1);
      chk("plan_depth_b_hold", b_depth, PAREN ? 2 : 0);

      clr_pulse(); run_str("1+");
      clr_pulse(); run_str("7");
      settle();
      chk("plan_after_clr_out", a_out, 1);

      clr_pulse(); run_str("1+1+1+1+1+1+1+1+1+1");
      settle();
      chk("sat_b_cnt", b_cnt, 7);
      chk("sat_a_cnt", a_cnt, 10);

      clr_pulse(); run_str("1234");
      clr_pulse(); run_str("12345");
      clr_pulse(); run_str("((1))*(2+3)");
      clr_pulse(); run_str("1)");
      clr_pulse(); run_str("(1)2");
      clr_pulse(); run_str("(1)(");
      clr_pulse(); run_str("+");
      clr_pulse(); run_str("1++");
      clr_pulse(); run_str("007*a");

      clr_pulse();
      send(1'b1, "4"); send(1'b0, "9"); send(1'b1, 8'h00); send(1'b1, "*");
      send(1'b1, 8'h00); send(1'b0, "+"); send(1'b1, "8");

      // clr held across an edge must win over a valid byte.
      @(negedge clk);
      clr = 1'b1; in_valid = 1'b1; in_b = "7";
      settle();
      chk("clr_over_valid_out", a_out, 0);
      chk("clr_over_valid_cnt", a_cnt, 0);
      ma = m_init(); mb = m_init();
      clr = 1'b0; in_valid = 1'b0;

      for (int s = 0; s < 300; s++) begin
         clr_pulse();
         len = $urandom_range(1, 16);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       send(1'b0, alpha[$urandom_range(0, alpha.len() - 1)]);
            else if (r < 13) send(1'b1, 8'h00);
            else if (r < 16) send(1'b1, 8'h61);
            else             send(1'b1, alpha[$urandom_range(0, alpha.len() - 1)]);
         end
      end

      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("queue_drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
